rd_req_fifo: RTL and testbench

Request buffer on each master leg of the cross-bar, directly downstream of the read-request switch. Accepts req/addr/wren beats from the switch's master-side rd_req port and stores them in order. Drives the fifo_full back-pressure flag consumed by the switch. Presents buffered requests to the target side with a valid/ready handshake.

---
 rtl/rd_req_fifo.sv | 99 +++++++++
 tb/tb_rd_req_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rd_req_fifo.sv
// rd_req_fifo
// Per-master-leg request buffer sitting directly behind the read-request
// switch. Beats of {wren, addr} are stored in arrival order. They are offered
// to the target side with a show-ahead valid/ready handshake: the head entry's
// data is valid in the same cycle as out_valid.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_req/addr/wren   push side from the switch's rd_req port
//   fifo_full          back-pressure to the switch (registered-count decode)
//   out_valid/ready    head-entry handshake toward the target
//   out_addr/out_wren  head entry (forced to 0 while empty)
//   level              current occupancy, 0..DEPTH
//   ovf_cnt            saturating count of in_req-while-full cycles; this port
//                      exists only when RD_REQ_FIFO_OVF_CNT_EN is defined
//
// Optional feature macro: RD_REQ_FIFO_OVF_CNT_EN
module rd_req_fifo #(
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_req,
  input  logic [AWIDTH-1:0]        in_addr,
  input  logic                     in_wren,
  output logic                     fifo_full,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AWIDTH-1:0]        out_addr,
  output logic                     out_wren,
  output logic [$clog2(DEPTH):0]   level
`ifdef RD_REQ_FIFO_OVF_CNT_EN
  ,
  output logic [15:0]              ovf_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);

  // Storage is deliberately not reset; the head is masked by out_valid.
  logic [AWIDTH:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;

  logic            w_push;
  logic            w_pop;
  logic [AWIDTH:0] w_head;

  // Flags come from the registered count only, so there is no combinational
  // path from in_req or out_ready back to the switch.
  assign fifo_full = (r_count == (PW+1)'(DEPTH));
  assign out_valid = (r_count != '0);
  assign level     = r_count;

  assign w_push = in_req && !fifo_full;
  assign w_pop  = out_valid && out_ready;

  assign w_head   = r_mem[r_rd_ptr];
  assign out_addr = out_valid ? w_head[AWIDTH-1:0] : '0;
  assign out_wren = out_valid ? w_head[AWIDTH]     : 1'b0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_wren, in_addr};
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

`ifdef RD_REQ_FIFO_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;
  logic        w_ovf;

  assign w_ovf   = in_req && fifo_full;
  assign ovf_cnt = r_ovf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_cnt <= '0;
    end else if (w_ovf && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rd_req_fifo.sv
module tb_rd_req_fifo;

  localparam int AWIDTH = 32;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_req = 1'b0;
  logic [AWIDTH-1:0] in_addr = '0;
  logic              in_wren = 1'b0;
  logic              fifo_full;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [AWIDTH-1:0] out_addr;
  logic              out_wren;
  logic [LW-1:0]     level;
`ifdef RD_REQ_FIFO_OVF_CNT_EN
  logic [15:0]       ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  rd_req_fifo #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_req    (in_req),
    .in_addr   (in_addr),
    .in_wren   (in_wren),
    .fifo_full (fifo_full),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_wren  (out_wren),
    .level     (level)
`ifdef RD_REQ_FIFO_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of {wren, addr} plus an overflow tally.
  logic [AWIDTH:0] mq[$];
  int unsigned     m_ovf = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      bit do_push, do_pop;
      do_push = in_req && (mq.size() < DEPTH);
      do_pop  = out_ready && (mq.size() != 0);
      if (in_req && mq.size() == DEPTH && m_ovf < 16'hFFFF) m_ovf++;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({in_wren, in_addr});
    end
  end

  // Outputs depend only on registered state, so checking on the falling edge
  // is race-free with respect to inputs changed there.
  always @(negedge clk) begin
    logic [AWIDTH:0] hd;
    hd = (mq.size() != 0) ? mq[0] : '0;
    chk("level",     64'(level),     64'(mq.size()));
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("fifo_full", 64'(fifo_full), 64'(mq.size() == DEPTH));
    chk("out_addr",  64'(out_addr),  64'(hd[AWIDTH-1:0]));
    chk("out_wren",  64'(out_wren),  64'(hd[AWIDTH]));
`ifdef RD_REQ_FIFO_OVF_CNT_EN
    chk("ovf_cnt",   64'(ovf_cnt),   64'(m_ovf));
`endif
  end

  // Drive one cycle's inputs, then advance to the next falling edge.
  task automatic step(input logic req, input logic [AWIDTH-1:0] a, input logic w, input logic rdy);
    in_req    = req;
    in_addr   = a;
    in_wren   = w;
    out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b0);
    chk("idle_level", 64'(level), 64'd0);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_full",  64'(fifo_full), 64'd0);
    chk("idle_addr",  64'(out_addr), 64'd0);

    // Single push, one-cycle latency, immediately consumed
    step(1'b1, 32'h10, 1'b0, 1'b1);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_addr",  64'(out_addr), 64'h10);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("lat_level", 64'(level), 64'd0);

    // Fill, overflow attempt, in-order drain
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    chk("fill_full",  64'(fifo_full), 64'd1);
    chk("fill_level", 64'(level), 64'd4);
    step(1'b1, 32'hA4, 1'b0, 1'b0);
    chk("ovf_level", 64'(level), 64'd4);
`ifdef RD_REQ_FIFO_OVF_CNT_EN
    chk("ovf_cnt_lit", 64'(ovf_cnt), 64'd1);
`endif
    for (int i = 0; i < 4; i++) begin
      chk("drain_addr", 64'(out_addr), 64'h0A0 + 64'(i));
      step(1'b0, '0, 1'b0, 1'b1);
    end
    chk("drain_level", 64'(level), 64'd0);

    // Full with simultaneous in_req and pop: push rejected
    for (int i = 0; i < 4; i++) step(1'b1, 32'h20 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hB0, 1'b0, 1'b1);
    chk("fp_level", 64'(level), 64'd3);
    chk("fp_full",  64'(fifo_full), 64'd0);
    for (int i = 1; i < 4; i++) begin
      chk("fp_addr", 64'(out_addr), 64'h20 + 64'(i));
      step(1'b0, '0, 1'b0, 1'b1);
    end
    chk("fp_empty", 64'(out_valid), 64'd0);

    // Steady push+pop at level 2, pointers wrap repeatedly
    step(1'b1, 32'h30, 1'b1, 1'b0);
    step(1'b1, 32'h31, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h40 + 32'(i), 1'(i % 2), 1'b1);
      chk("steady_level", 64'(level), 64'd2);
    end
    chk("steady_addr", 64'(out_addr), 64'h40 + 64'd18);
    chk("steady_wren", 64'(out_wren), 64'd0);
    drain();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
    in_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_addr",  64'(out_addr), 64'd0);
    chk("arst_full",  64'(fifo_full), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'hC0, 1'b1, 1'b0);
    chk("post_addr",  64'(out_addr), 64'hC0);
    chk("post_wren",  64'(out_wren), 64'd1);
    chk("post_level", 64'(level), 64'd1);
    drain();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) < 65), $urandom, 1'($urandom), 1'($urandom_range(0, 99) < 45));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
